// File: rtl/mux_s2m_if.sv
// AHB slave-to-master return-path bundle: muxed address phase in, per-slave
// responses in, selects and merged response out.
interface mux_s2m_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HSELx0;
    logic              HSELx1;
    logic [DATA_W-1:0] HRDATA0;
    logic [DATA_W-1:0] HRDATA1;
    logic              HREADYOUT0;
    logic              HREADYOUT1;
    logic [1:0]        HRESP0;
    logic [1:0]        HRESP1;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic [CNT_W-1:0]  ERR_CNT;

    // The mux itself sits on the slave side of this bundle.
    modport slave (
        input  HADDR, HTRANS,
        input  HRDATA0, HRDATA1, HREADYOUT0, HREADYOUT1, HRESP0, HRESP1,
        output HSELx0, HSELx1,
        output HRDATA, HREADY, HRESP, ERR_CNT
    );

    modport master (
        output HADDR, HTRANS,
        output HRDATA0, HRDATA1, HREADYOUT0, HREADYOUT1, HRESP0, HRESP1,
        input  HSELx0, HSELx1,
        input  HRDATA, HREADY, HRESP, ERR_CNT
    );
endinterface

// File: rtl/mux_s2m.sv
// AHB return path: address decode, data-phase select register, response mux,
// built-in default slave (two-cycle ERROR) and saturating decode-error counter.
module mux_s2m #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hF000_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    mux_s2m_if.slave   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_S0  = 2'd0,
        DS_S1  = 2'd1,
        DS_DEF = 2'd2
    } dsel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dstate_t;

    logic              sel0_c;
    logic              sel1_c;
    logic              seldef_c;
    logic              active_c;
    logic              accept_c;
    dsel_t             dsel_nxt_c;
    dsel_t             dsel;
    dstate_t           state;
    logic              def_ready;
    logic [1:0]        def_resp;
    logic [CNT_W-1:0]  err_cnt;
    logic [DATA_W-1:0] hrdata_c;
    logic              hready_c;
    logic [1:0]        hresp_c;

    // Address decode, S0 wins on overlap; independent of HTRANS.
    assign sel0_c   = ((bus.HADDR & S0_MASK) == S0_BASE);
    assign sel1_c   = !sel0_c && ((bus.HADDR & S1_MASK) == S1_BASE);
    assign seldef_c = !sel0_c && !sel1_c;

    assign bus.HSELx0 = sel0_c;
    assign bus.HSELx1 = sel1_c;

    assign active_c = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
    assign accept_c = hready_c && seldef_c && active_c;

    always_comb begin
        dsel_nxt_c = DS_DEF;
        if (sel0_c)      dsel_nxt_c = DS_S0;
        else if (sel1_c) dsel_nxt_c = DS_S1;
    end

    // Response mux; combinational from dsel so the data phase adds no latency.
    always_comb begin
        hrdata_c = '0;
        hready_c = def_ready;
        hresp_c  = def_resp;
        case (dsel)
            DS_S0: begin
                hrdata_c = bus.HRDATA0;
                hready_c = bus.HREADYOUT0;
                hresp_c  = bus.HRESP0;
            end
            DS_S1: begin
                hrdata_c = bus.HRDATA1;
                hready_c = bus.HREADYOUT1;
                hresp_c  = bus.HRESP1;
            end
            default: ;
        endcase
    end

    assign bus.HRDATA  = hrdata_c;
    assign bus.HREADY  = hready_c;
    assign bus.HRESP   = hresp_c;
    assign bus.ERR_CNT = err_cnt;

    // Data-phase select only advances when the bus is not stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)      dsel <= DS_DEF;
        else if (hready_c) dsel <= dsel_nxt_c;
    end

    // Default slave: ready/resp are registered alongside the state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            def_ready <= 1'b1;
            def_resp  <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        state     <= ST_ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= RESP_ERROR;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    def_ready <= 1'b1;
                    def_resp  <= RESP_ERROR;
                end
                ST_ERR2: begin
                    if (accept_c) begin
                        state     <= ST_ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= RESP_ERROR;
                    end else begin
                        state     <= ST_IDLE;
                        def_ready <= 1'b1;
                        def_resp  <= RESP_OKAY;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    def_ready <= 1'b1;
                    def_resp  <= RESP_OKAY;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                             err_cnt <= '0;
        else if (accept_c && (err_cnt != '1))     err_cnt <= err_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_mux_s2m.sv
// Scoreboard bench for mux_s2m: each accepted address phase queues the
// expected data phase, which is checked cycle by cycle until it completes.
module tb_mux_s2m;
    localparam logic [1:0] T_S0  = 2'd0;
    localparam logic [1:0] T_S1  = 2'd1;
    localparam logic [1:0] T_DEF = 2'd2;

    localparam logic [31:0] RD0 = 32'hA5A5_0001;
    localparam logic [31:0] RD1 = 32'h0000_00F0;
    localparam logic [31:0] UNM = 32'h8000_0000;

    typedef struct packed {
        logic [1:0] tgt;
        logic       act;
        logic       first;
    } sb_t;

    logic HCLK;
    logic HRESETn;
    mux_s2m_if bus();

    mux_s2m dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    sb_t sbq[$];
    int  checks    = 0;
    int  errors    = 0;
    int  model_cnt = 0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare one cycle's outputs against the queue head, then retire/queue.
    task automatic check_cycle();
        logic [1:0]  tgt;
        logic        act;
        logic        first;
        logic        exp_ready;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        logic [1:0]  ntgt;
        sb_t         item;
        if (sbq.size() == 0) begin
            tgt = T_DEF; act = 1'b0; first = 1'b0;
        end else begin
            tgt = sbq[0].tgt; act = sbq[0].act; first = sbq[0].first;
        end
        case (tgt)
            T_S0:    begin exp_ready = bus.HREADYOUT0; exp_resp = bus.HRESP0; exp_data = RD0; end
            T_S1:    begin exp_ready = bus.HREADYOUT1; exp_resp = bus.HRESP1; exp_data = RD1; end
            default: begin exp_ready = !(act && first); exp_resp = act ? 2'b01 : 2'b00; exp_data = 32'h0; end
        endcase
        check_eq("hready",  32'(bus.HREADY),  32'(exp_ready));
        check_eq("hresp",   32'(bus.HRESP),   32'(exp_resp));
        check_eq("hrdata",  bus.HRDATA,       exp_data);
        check_eq("hsel0",   32'(bus.HSELx0),  32'(bus.HADDR[31:28] == 4'h0));
        check_eq("hsel1",   32'(bus.HSELx1),  32'(bus.HADDR[31:28] == 4'h1));
        check_eq("err_cnt", 32'(bus.ERR_CNT), 32'(model_cnt));
        if (exp_ready) begin
            if (sbq.size() > 0) void'(sbq.pop_front());
            if (bus.HADDR[31:28] == 4'h0)      ntgt = T_S0;
            else if (bus.HADDR[31:28] == 4'h1) ntgt = T_S1;
            else                               ntgt = T_DEF;
            item.tgt   = ntgt;
            item.act   = bus.HTRANS[1];
            item.first = 1'b1;
            sbq.push_back(item);
            if (ntgt == T_DEF && item.act && model_cnt < 255) model_cnt++;
        end else if (sbq.size() > 0 && sbq[0].tgt == T_DEF) begin
            sbq[0].first = 1'b0;
        end
    endtask

    task automatic step(input logic [31:0] a, input logic [1:0] t, input logic r0, input logic r1);
        @(negedge HCLK);
        bus.HADDR      = a;
        bus.HTRANS     = t;
        bus.HREADYOUT0 = r0;
        bus.HREADYOUT1 = r1;
        #1;
        check_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hready"}, 32'(bus.HREADY),  32'd1);
        check_eq({tag, "_hresp"},  32'(bus.HRESP),   32'd0);
        check_eq({tag, "_hrdata"}, bus.HRDATA,       32'h0);
        check_eq({tag, "_cnt"},    32'(bus.ERR_CNT), 32'd0);
    endtask

    initial begin
        HRESETn        = 1'b0;
        bus.HADDR      = 32'h0000_0010;
        bus.HTRANS     = 2'b10;
        bus.HRDATA0    = RD0;
        bus.HRDATA1    = RD1;
        bus.HREADYOUT0 = 1'b0;
        bus.HREADYOUT1 = 1'b0;
        bus.HRESP0     = 2'b00;
        bus.HRESP1     = 2'b00;
        #12;
        check_reset_outputs("rst");
        check_eq("rst_hsel0", 32'(bus.HSELx0), 32'd1);

        @(negedge HCLK);
        bus.HADDR  = UNM;
        bus.HTRANS = 2'b00;
        HRESETn    = 1'b1;

        // S0 read, then an idle to an unmapped address
        step(32'h0000_0010, 2'b10, 1'b1, 1'b1);
        step(UNM,           2'b00, 1'b1, 1'b1);
        // S1 with two wait states while S0 address is held
        step(32'h1000_0000, 2'b10, 1'b1, 1'b1);
        step(32'h0000_0004, 2'b10, 1'b1, 1'b0);
        step(32'h0000_0004, 2'b10, 1'b1, 1'b0);
        step(32'h0000_0004, 2'b10, 1'b1, 1'b1);
        // S0 data phase with SPLIT passed through; unmapped NONSEQ queued
        bus.HRESP0 = 2'b11;
        step(UNM, 2'b10, 1'b1, 1'b1);
        bus.HRESP0 = 2'b00;
        step(UNM, 2'b00, 1'b1, 1'b1);
        step(UNM, 2'b00, 1'b1, 1'b1);
        step(UNM, 2'b00, 1'b1, 1'b1);
        check_eq("cnt_one", 32'(bus.ERR_CNT), 32'd1);

        // Back-to-back unmapped NONSEQ up to saturation
        for (int i = 0; i < 300; i++) begin
            step(UNM | (32'(i) << 2), 2'b10, 1'b1, 1'b1);
            step(UNM | (32'(i) << 2), 2'b10, 1'b1, 1'b1);
        end
        step(UNM, 2'b00, 1'b1, 1'b1);
        step(UNM, 2'b00, 1'b1, 1'b1);
        step(UNM, 2'b00, 1'b1, 1'b1);
        check_eq("cnt_sat", 32'(bus.ERR_CNT), 32'hFF);

        // Reset asserted while the default slave is in ERR1
        step(32'h9000_0000, 2'b10, 1'b1, 1'b1);
        step(UNM,           2'b00, 1'b1, 1'b1);
        check_eq("err1_hready", 32'(bus.HREADY), 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sbq.delete();
        model_cnt = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Normal operation resumes after reset
        step(32'h0000_0020, 2'b10, 1'b1, 1'b1);
        step(32'h1000_0008, 2'b11, 1'b1, 1'b1);
        step(UNM,           2'b00, 1'b1, 1'b1);
        step(UNM,           2'b00, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_s2m.md
# mux_s2m

Slave-to-master return path of the AHB fabric: decodes the shared address bus into slave selects, registers the selection into the data phase, and multiplexes HRDATA, HREADY and HRESP from the RAM slave (S0) and the GPIO slave (S1) back to the granted master. It contains the built-in default slave, which gives the two-cycle ERROR response for unmapped addresses, plus a saturating decode-error counter. It sits between the master-to-slave multiplexer output and the slaves.

## Interface
- S0_BASE, 32'h0000_0000, RAM region base.
- S0_MASK, 32'hF000_0000, RAM region compare mask.
- S1_BASE, 32'h1000_0000, GPIO region base.
- S1_MASK, 32'hF000_0000, GPIO region compare mask.

Ports:
- HCLK  in  1  bus clock; one clock, all state on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HADDR  in  32  muxed master address.
- HTRANS  in  2  muxed master transfer type.
- HSELx0  out  1  RAM select (address phase).
- HSELx1  out  1  GPIO select (address phase).
- HRDATA0, HRDATA1  in  32  slave read data.
- HREADYOUT0, HREADYOUT1  in  1  slave ready.
- HRESP0, HRESP1  in  2  slave response.
- HRDATA  out  32  read data to masters.
- HREADY  out  1  global ready, fed back to masters and slaves.
- HRESP  out  2  response to masters (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT).
- ERR_CNT  out  8  count of decode-error transfers, saturating.

## Operation
- Decode is combinational: HSELx0 = ((HADDR & S0_MASK) == S0_BASE). HSELx1 = the same compare for S1, gated by !HSELx0, so S0 wins on overlap. The default slave is selected when neither matches.
- Decode is independent of HTRANS. The slaves qualify HSEL with HTRANS themselves.
- Data-phase select register dsel (S0, S1, DEF):
  - Loaded with the decoded select on a rising edge when HREADY=1.
  - Held when HREADY=0.
  - Reset value DEF.
- Output mux on dsel:
  - S0 → HRDATA0 / HREADYOUT0 / HRESP0.
  - S1 → HRDATA1 / HREADYOUT1 / HRESP1.
  - DEF → 32'h0 / default-slave ready / default-slave response.
- Slave HRESP values are passed through unmodified, including RETRY and SPLIT.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - Transfer accepted = HREADY=1, decode=DEF, and HTRANS=NONSEQ(10) or SEQ(11).
  - IDLE: ready=1, resp=OKAY. On transfer accepted → ERR1.
  - ERR1: ready=0, resp=ERROR. Always → ERR2.
  - ERR2: ready=1, resp=ERROR. On transfer accepted → ERR1, otherwise → IDLE.
  - HTRANS IDLE(00) or BUSY(01) to an unmapped address: stay in IDLE, OKAY zero-wait.
- ERR_CNT:
  - Increments by 1 on each transfer accepted.
  - Saturates at 8'hFF.
  - Cleared only by reset.

## Timing
- Reset (async, HRESETn=0):
  - dsel=DEF, FSM=IDLE, ERR_CNT=0.
  - Hence HREADY=1, HRESP=00, HRDATA=32'h0 immediately, without waiting for a clock edge.
  - HSELx0/1 follow HADDR combinationally even in reset.
- Reset asserted mid-operation (e.g. in ERR1 or during an S1 wait state) aborts the transfer. Outputs take reset values asynchronously.
- Address-phase select: zero latency.
- Data-phase return: one cycle after the address phase is accepted, and extended by every cycle the selected slave drives HREADYOUT=0.
- Wait-state hold: while HREADY=0, a new address aimed at another slave does not change dsel. dsel switches on the first edge with HREADY=1.
- Decode error: exactly two data-phase cycles (ERR1 with HREADY=0, then ERR2 with HREADY=1), both with HRESP=01.
- Back-to-back unmapped NONSEQ transfers repeat ERR1→ERR2 with no IDLE cycle between them.
- HRDATA is combinational from dsel. It is not registered: no added latency.

## Test plan
- Reset: HRESETn=0 with arbitrary inputs → HREADY=1, HRESP=00, HRDATA=0, ERR_CNT=0. Deassert → still OKAY, zero-wait.
- S0 read: HADDR=0x0000_0010, HTRANS=10, HREADYOUT0=1 → HSELx0=1 in the same cycle. Next cycle HRDATA=HRDATA0 (0xA5A5_0001), HRESP=00.
- S1 wait states, then S0: S1 address phase, then HREADYOUT1=0 for 2 cycles while HADDR=0x0000_0004 → HREADY=0 for 2 cycles and dsel stays S1. HRDATA1=0x0000_00F0 is returned, then S0 data follows.
- Unmapped: HADDR=0x8000_0000, HTRANS=10 → next cycle HREADY=0/HRESP=01, then HREADY=1/HRESP=01, ERR_CNT=1. A following IDLE gives OKAY.
- Unmapped address with HTRANS=00 → no error, HRESP=00, ERR_CNT unchanged. Then 300 consecutive unmapped NONSEQ transfers → every one errors, ERR_CNT saturates at 8'hFF.
- Reset asserted during ERR1 → HREADY=1 and HRESP=00 immediately, ERR_CNT=0.
